alu_seq: RTL and testbench

//  Initiator/sequencer for the combinational 4-bit-opcode ALU. Accepts operation

---
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: valid/ready sequencer for a 32-bit ALU, chaining 64-bit add/sub as three passes; ALU_SEQ_STICKY_FLAGS_EN adds flag_c/flag_z
//   clk, rst (sync, active-high)
//   req_valid/req_ready/req_op/req_wide/req_a/req_b : request channel
//   alu_opcode/alu_in1/alu_in2 -> ALU, alu_out/alu_carry/alu_zero <- ALU
//   rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_zero : response channel
//   busy : sequencer not idle
//   flag_c/flag_z : sticky copies of the last delivered carry/zero (ALU_SEQ_STICKY_FLAGS_EN only)
module alu_seq #(
  parameter logic [3:0] IDLE_OPCODE = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_wide,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  output logic        flag_c,
  output logic        flag_z,
`endif
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LO, HI1, HI2, RSP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        wide_q, wide_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [31:0] lo_q, lo_d, h1_q, h1_d, hi_q, hi_d;
  logic        c0_q, c0_d, z0_q, z0_d, c1_q, c1_d, c2_q, c2_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic        alu_act;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`endif
  assign req_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_act    = state_q == LO || state_q == HI1 || state_q == HI2;
  // HI2 folds the low-half carry/borrow into the upper partial result
  assign alu_opcode = alu_act ? op_q : IDLE_OPCODE;
  assign alu_in1    = state_q == LO ? a_q[31:0] : state_q == HI1 ? a_q[63:32] : state_q == HI2 ? h1_q : '0;
  assign alu_in2    = state_q == LO ? b_q[31:0] : state_q == HI1 ? b_q[63:32] : state_q == HI2 ? {31'b0, c0_q} : '0;
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_d         = lo_q;
    h1_d         = h1_q;
    hi_d         = hi_q;
    c0_d         = c0_q;
    z0_d         = z0_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    flag_c_d     = rsp_valid_q && rsp_ready ? rsp_carry_q : flag_c_q;
    flag_z_d     = rsp_valid_q && rsp_ready ? rsp_zero_q : flag_z_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LO;
        op_d    = req_op;
        wide_d  = req_wide && (req_op == 4'h1 || req_op == 4'h2);
        a_d     = req_a;
        b_d     = req_b;
      end
      LO: begin
        lo_d    = alu_out;
        c0_d    = alu_carry;
        z0_d    = alu_zero;
        state_d = wide_q ? HI1 : RSP;
      end
      HI1: begin
        h1_d    = alu_out;
        c1_d    = alu_carry;
        state_d = HI2;
      end
      HI2: begin
        hi_d    = alu_out;
        c2_d    = alu_carry;
        state_d = RSP;
      end
      RSP: if (!rsp_valid_q) begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = wide_q ? {hi_q, lo_q} : {32'b0, lo_q};
        rsp_carry_d  = wide_q ? c1_q | c2_q : c0_q;
        rsp_zero_d   = wide_q ? z0_q && hi_q == '0 : z0_q;
      end else if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      lo_q         <= '0;
      h1_q         <= '0;
      hi_q         <= '0;
      c0_q         <= 1'b0;
      z0_q         <= 1'b0;
      c1_q         <= 1'b0;
      c2_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wide_q       <= wide_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lo_q         <= lo_d;
      h1_q         <= h1_d;
      hi_q         <= hi_d;
      c0_q         <= c0_d;
      z0_q         <= z0_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq with a behavioural ALU and reference model
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wide = 1'b0;
  logic [3:0]  req_op = '0, alu_opcode;
  logic [63:0] req_a = '0, req_b = '0, rsp_result;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        alu_carry, alu_zero, rsp_valid, rsp_ready = 1'b0, rsp_carry, rsp_zero, busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        flag_c, flag_z;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    .flag_c(flag_c), .flag_z(flag_z),
`endif
    .busy(busy)
  );
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_opcode)
      4'h1: {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'h2: begin alu_out = alu_in1 - alu_in2; alu_carry = alu_in1 < alu_in2; end
      4'h3: alu_out = alu_in1 << alu_in2[4:0];
      4'h4: alu_out = alu_in1 >> alu_in2[4:0];
      4'h5: alu_out = $signed(alu_in1) >>> alu_in2[4:0];
      4'h6: alu_out = alu_in1 & alu_in2;
      4'h7: alu_out = alu_in1 | alu_in2;
      4'h8: alu_out = alu_in1 ^ alu_in2;
      4'h9: alu_out = ~alu_in1;
      default: alu_out = '0;
    endcase
    alu_zero = alu_out == '0;
  end
  function automatic logic [65:0] ref_op(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [31:0] r;
    logic        c;
    if (w && (op == 4'h1 || op == 4'h2)) begin
      s = op == 4'h1 ? {1'b0, a} + {1'b0, b} : {a < b, a - b};
      return {s[63:0] == '0, s[64], s[63:0]};
    end
    c = 1'b0;
    case (op)
      4'h1: {c, r} = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      4'h2: begin r = a[31:0] - b[31:0]; c = a[31:0] < b[31:0]; end
      4'h3: r = a[31:0] << b[4:0];
      4'h4: r = a[31:0] >> b[4:0];
      4'h5: r = $signed(a[31:0]) >>> b[4:0];
      4'h6: r = a[31:0] & b[31:0];
      4'h7: r = a[31:0] | b[31:0];
      4'h8: r = a[31:0] ^ b[31:0];
      4'h9: r = ~a[31:0];
      default: r = '0;
    endcase
    return {r == '0, c, 32'b0, r};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] er, input logic ec, input logic ez, input int stall);
    int lat;
    logic [63:0] r0;
    lat = 0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_wide = w; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy", busy, 1);
    chk("lo_opcode", alu_opcode, op);
    chk("lo_in1", alu_in1, a[31:0]);
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (w && (op == 4'h1 || op == 4'h2)) ? 4 : 2);
    chk("result", rsp_result, er);
    chk("carry", rsp_carry, ec);
    chk("zero", rsp_zero, ez);
    r0 = rsp_result;
    req_valid = stall > 0; req_a = ~a; req_b = ~b;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", rsp_result, r0);
      chk("stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("flag_c", flag_c, ec);
    chk("flag_z", flag_z, ez);
`endif
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0]  op;
    logic        w;
    logic [63:0] a, b;
    logic [65:0] e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_in1", alu_in1, 0);
    run(4'h1, 1'b0, 64'hFFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b1, 0);
    run(4'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h1_0000_0000, 1'b0, 1'b0, 0);
    run(4'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b1, 0);
    run(4'h2, 1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 5);
    run(4'hC, 1'b0, 64'h1234, 64'h5678, 64'h0, 1'b0, 1'b1, 1);
    run(4'h3, 1'b1, 64'hFFFF_FFFF_0000_0001, 64'h4, 64'h10, 1'b0, 1'b0, 0);
    run(4'h2, 1'b1, 64'h5, 64'h5, 64'h0, 1'b0, 1'b1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'h1; req_wide = 1'b1; req_a = 64'h1111_2222_3333_4444; req_b = 64'h1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("hi1_opcode", alu_opcode, 4'h1);
    chk("hi1_in1", alu_in1, 32'h1111_2222);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_opcode", alu_opcode, 0);
    chk("abort_busy", busy, 0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("abort_flag_c", flag_c, 0);
    chk("abort_flag_z", flag_z, 0);
`endif
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", rsp_valid, 0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()};
      b  = $urandom_range(0, 3) == 0 ? a : {$urandom(), $urandom()};
      e  = ref_op(op, w, a, b);
      run(op, w, a, b, e[63:0], e[64], e[65], $urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
